avalon_mem_master: RTL and testbench

Avalon-MM master that sits between the CPU load/store stage and the Avalon RAM slave. It accepts one sized, optionally signed memory request at a time. It turns the request into a word-aligned Avalon read or write with the correct byteenable and lane-replicated writedata, and holds it until the slave drops waitrequest. It then returns lane-extracted, sign- or zero-extended load data, or an error for misaligned accesses and slave timeouts.

---
 rtl/mem_pkg.sv | 57 +++++
 rtl/load_align.sv | 34 +++
 rtl/avalon_mem_master.sv | 177 +++++++++++++++++
 tb/tb_avalon_mem_master.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the Avalon memory master.
//   mem_size_t     : access size (byte / half / word)
//   master_state_t : master FSM states
//   size_of        : maps the raw 2-bit CPU size field (3 -> word)
//   be_of          : byteenable lane mask for a size and byte offset
//   misaligned     : true when the access cannot be issued as one bus cycle
//   wdata_of       : lane-replicated store data
package mem_pkg;

  typedef enum logic [1:0] {
    MemByte = 2'd0,
    MemHalf = 2'd1,
    MemWord = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } master_state_t;

  function automatic mem_size_t size_of(input logic [1:0] sz);
    case (sz)
      2'd0:    return MemByte;
      2'd1:    return MemHalf;
      default: return MemWord;
    endcase
  endfunction

  function automatic logic [3:0] be_of(input mem_size_t size, input logic [1:0] lane);
    case (size)
      MemByte: return 4'b0001 << lane;
      MemHalf: return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input mem_size_t size, input logic [1:0] lane);
    case (size)
      MemHalf: return lane[0];
      MemWord: return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Replicating across all lanes means the slave picks the right bytes via byteenable
  // regardless of offset.
  function automatic logic [31:0] wdata_of(input mem_size_t size, input logic [31:0] wdata);
    case (size)
      MemByte: return {4{wdata[7:0]}};
      MemHalf: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load lane select and sign/zero extension.
//   i_data   : 32-bit word as read from the bus
//   i_lane   : byte offset within the word (addr[1:0])
//   i_size   : access size
//   i_signed : sign-extend (byte/half only)
//   o_result : right-justified, extended result
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [1:0]  i_lane,
  input  mem_size_t   i_size,
  input  logic        i_signed,
  output logic [31:0] o_result
);

  logic [31:0] w_byte_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte_shift = i_data >> {i_lane, 3'b000};
  assign w_byte       = w_byte_shift[7:0];
  assign w_half       = i_lane[1] ? i_data[31:16] : i_data[15:0];

  always_comb begin
    o_result = i_data;
    case (i_size)
      MemByte: o_result = {{24{i_signed & w_byte[7]}}, w_byte};
      MemHalf: o_result = {{16{i_signed & w_half[15]}}, w_half};
      default: o_result = i_data;
    endcase
  end

endmodule

// File: rtl/avalon_mem_master.sv
// Avalon-MM master between the CPU load/store stage and an Avalon RAM slave.
// Accepts one sized request at a time, issues a word-aligned read/write with the
// proper byteenable and replicated writedata, waits out waitrequest (with optional
// timeout) and returns extended load data or an error.
//   clk, reset_n                  : clock, async active-low reset
//   req_*                         : CPU request handshake and payload
//   resp_valid/resp_rdata/resp_err: one-cycle response
//   address/byteenable/read/write/writedata/waitrequest/readdata : Avalon-MM master
module avalon_mem_master
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic [3:0]  byteenable,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  master_state_t r_state, w_state_d;

  // Latched request fields (full address and wdata live in the bus output registers).
  logic [1:0]  r_lane,   w_lane_d;
  mem_size_t   r_size,   w_size_d;
  logic        r_signed, w_signed_d;
  logic        r_is_wr,  w_is_wr_d;

  logic [7:0]  r_cnt,    w_cnt_d;
  logic [7:0]  w_cnt_inc;

  logic        r_read,   w_read_d;
  logic        r_write,  w_write_d;
  logic [31:0] r_addr,   w_addr_d;
  logic [3:0]  r_be,     w_be_d;
  logic [31:0] r_wdata,  w_wdata_d;

  logic        r_rvalid, w_rvalid_d;
  logic [31:0] r_rdata,  w_rdata_d;
  logic        r_err,    w_err_d;

  mem_size_t   w_in_size;
  logic [31:0] w_load_data;

  assign w_in_size = size_of(req_size);
  assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

  load_align u_load_align (
    .i_data   (readdata),
    .i_lane   (r_lane),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_result (w_load_data)
  );

  always_comb begin
    w_state_d  = r_state;
    w_lane_d   = r_lane;
    w_size_d   = r_size;
    w_signed_d = r_signed;
    w_is_wr_d  = r_is_wr;
    w_cnt_d    = r_cnt;
    w_read_d   = r_read;
    w_write_d  = r_write;
    w_addr_d   = r_addr;
    w_be_d     = r_be;
    w_wdata_d  = r_wdata;
    w_rvalid_d = 1'b0;
    w_rdata_d  = 32'd0;
    w_err_d    = 1'b0;

    case (r_state)
      StIdle: begin
        if (req_valid) begin
          w_lane_d   = req_addr[1:0];
          w_size_d   = w_in_size;
          w_signed_d = req_signed;
          w_is_wr_d  = req_write;
          if (misaligned(w_in_size, req_addr[1:0])) begin
            w_state_d  = StResp;
            w_rvalid_d = 1'b1;
            w_err_d    = 1'b1;
          end else begin
            w_state_d = StReq;
            w_cnt_d   = 8'd0;
            w_read_d  = ~req_write;
            w_write_d = req_write;
            w_addr_d  = {req_addr[31:2], 2'b00};
            w_be_d    = be_of(w_in_size, req_addr[1:0]);
            w_wdata_d = req_write ? wdata_of(w_in_size, req_wdata) : 32'd0;
          end
        end
      end
      // The slave registers its stall, so waitrequest is meaningless here.
      StReq: w_state_d = StWait;
      StWait: begin
        if (!waitrequest) begin
          w_state_d  = StResp;
          w_read_d   = 1'b0;
          w_write_d  = 1'b0;
          w_rvalid_d = 1'b1;
          w_rdata_d  = r_is_wr ? 32'd0 : w_load_data;
        end else begin
          w_cnt_d = w_cnt_inc;
          if (TIMEOUT_CYCLES != 0 && 32'(w_cnt_inc) >= TIMEOUT_CYCLES) begin
            w_state_d  = StResp;
            w_read_d   = 1'b0;
            w_write_d  = 1'b0;
            w_rvalid_d = 1'b1;
            w_err_d    = 1'b1;
          end
        end
      end
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= StIdle;
      r_lane   <= 2'd0;
      r_size   <= MemByte;
      r_signed <= 1'b0;
      r_is_wr  <= 1'b0;
      r_cnt    <= 8'd0;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= 32'd0;
      r_be     <= 4'd0;
      r_wdata  <= 32'd0;
      r_rvalid <= 1'b0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_lane   <= w_lane_d;
      r_size   <= w_size_d;
      r_signed <= w_signed_d;
      r_is_wr  <= w_is_wr_d;
      r_cnt    <= w_cnt_d;
      r_read   <= w_read_d;
      r_write  <= w_write_d;
      r_addr   <= w_addr_d;
      r_be     <= w_be_d;
      r_wdata  <= w_wdata_d;
      r_rvalid <= w_rvalid_d;
      r_rdata  <= w_rdata_d;
      r_err    <= w_err_d;
    end
  end

  assign req_ready  = (r_state == StIdle);
  assign resp_valid = r_rvalid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign address    = r_addr;
  assign byteenable = r_be;
  assign read       = r_read;
  assign write      = r_write;
  assign writedata  = r_wdata;

endmodule

// File: tb/tb_avalon_mem_master.sv
module tb_avalon_mem_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] address, writedata, readdata;
  logic [3:0]  byteenable;
  logic        read, write, waitrequest;

  // Second instance with a short timeout and a permanently stalled slave.
  logic        t_req_valid, t_req_ready, t_resp_valid, t_resp_err;
  logic [31:0] t_req_addr, t_resp_rdata, t_address, t_writedata;
  logic [3:0]  t_byteenable;
  logic        t_read, t_write;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t t_sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  avalon_mem_master dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .address     (address),
    .byteenable  (byteenable),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .waitrequest (waitrequest),
    .readdata    (readdata)
  );

  avalon_mem_master #(.TIMEOUT_CYCLES(3)) dut_to (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (t_req_valid),
    .req_ready   (t_req_ready),
    .req_write   (1'b0),
    .req_size    (2'd2),
    .req_signed  (1'b0),
    .req_addr    (t_req_addr),
    .req_wdata   (32'd0),
    .resp_valid  (t_resp_valid),
    .resp_rdata  (t_resp_rdata),
    .resp_err    (t_resp_err),
    .address     (t_address),
    .byteenable  (t_byteenable),
    .read        (t_read),
    .write       (t_write),
    .writedata   (t_writedata),
    .waitrequest (1'b1),
    .readdata    (32'hA5A5_A5A5)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && resp_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_resp: got rdata %0h err %0b expected none", resp_rdata,
                 resp_err);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
        check("resp_err", 64'(resp_err), 64'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && t_resp_valid) begin
      if (t_sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL t_unexpected_resp: got err %0b expected none", t_resp_err);
      end else begin
        exp_t e;
        e = t_sb_q.pop_front();
        check("t_resp_rdata", 64'(t_resp_rdata), 64'(e.rdata));
        check("t_resp_err", 64'(t_resp_err), 64'(e.err));
      end
    end
  end

  // One request; exp_err set means a misaligned access (no bus cycle expected).
  task automatic do_req(input string name, input logic wr, input logic [1:0] sz,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                        input int stall, input logic [31:0] exp_rdata, input logic exp_err,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd);
    int lat;
    int strobe_cyc;
    int exp_lat;
    lat        = 0;
    strobe_cyc = 0;
    exp_lat    = exp_err ? 1 : 3 + stall;
    @(negedge clk);
    check({name, "_ready"}, 64'(req_ready), 64'd1);
    req_valid   = 1'b1;
    req_write   = wr;
    req_size    = sz;
    req_signed  = sgn;
    req_addr    = addr;
    req_wdata   = wd;
    waitrequest = 1'b0;
    sb_q.push_back('{exp_rdata, exp_err});
    @(posedge clk);
    #1;
    // Scramble inputs: the master must use its latched copy.
    req_valid  = 1'b0;
    req_write  = ~wr;
    req_size   = ~sz;
    req_signed = ~sgn;
    req_addr   = ~addr;
    req_wdata  = ~wd;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (read || write) begin
        strobe_cyc++;
        check({name, "_bus"}, {address, byteenable, read, write},
              {{addr[31:2], 2'b00}, exp_be, ~wr, wr});
        if (wr) check({name, "_wdata"}, 64'(writedata), 64'(exp_wd));
      end
      if (k >= 2) waitrequest = (k - 2 < stall);
      if (resp_valid) begin
        lat = k;
        break;
      end
    end
    waitrequest = 1'b0;
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_strobe_cycles"}, 64'(strobe_cyc), exp_err ? 64'd0 : 64'(2 + stall));
    @(negedge clk);
    check({name, "_after"}, {resp_valid, resp_err, resp_rdata}, 64'd0);
  endtask

  initial begin
    int lat;
    int strobe_cyc;
    reset_n     = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_size    = 2'd0;
    req_signed  = 1'b0;
    req_addr    = 32'd0;
    req_wdata   = 32'd0;
    waitrequest = 1'b0;
    readdata    = 32'h8081_F27F;
    t_req_valid = 1'b0;
    t_req_addr  = 32'd0;
    #12;
    check("reset_bus", {read, write, address, byteenable, writedata[23:0]}, 64'd0);
    check("reset_resp", {resp_valid, resp_err, resp_rdata, writedata[31:24]}, 64'd0);
    check("reset_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;

    //     name        wr    sz    sgn   addr          wdata         stall rdata         err   be       wd
    do_req("ldb_s",    1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'd0,        0, 32'hFFFF_FF80, 1'b0, 4'b1000, 32'd0);
    do_req("ldb_u",    1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'd0,        1, 32'h0000_0080, 1'b0, 4'b1000, 32'd0);
    do_req("ldb_s1",   1'b0, 2'd0, 1'b1, 32'h0000_0101, 32'd0,        0, 32'hFFFF_FFF2, 1'b0, 4'b0010, 32'd0);
    do_req("ldb_s0",   1'b0, 2'd0, 1'b1, 32'h0000_0100, 32'd0,        0, 32'h0000_007F, 1'b0, 4'b0001, 32'd0);
    do_req("ldh_s",    1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'd0,        0, 32'hFFFF_8081, 1'b0, 4'b1100, 32'd0);
    do_req("ldh_u",    1'b0, 2'd1, 1'b0, 32'h0000_0100, 32'd0,        0, 32'h0000_F27F, 1'b0, 4'b0011, 32'd0);
    do_req("ldw_sz3",  1'b0, 2'd3, 1'b1, 32'h0000_0100, 32'd0,        0, 32'h8081_F27F, 1'b0, 4'b1111, 32'd0);
    do_req("sth",      1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 2, 32'd0,        1'b0, 4'b1100, 32'hABCD_ABCD);
    do_req("stb",      1'b1, 2'd0, 1'b0, 32'h0000_0201, 32'h0000_0055, 0, 32'd0,        1'b0, 4'b0010, 32'h5555_5555);
    do_req("stw",      1'b1, 2'd2, 1'b0, 32'h0000_0204, 32'hCAFE_F00D, 0, 32'd0,        1'b0, 4'b1111, 32'hCAFE_F00D);
    do_req("misw",     1'b0, 2'd2, 1'b0, 32'h0000_0301, 32'd0,        0, 32'd0,        1'b1, 4'b0000, 32'd0);
    do_req("mish_st",  1'b1, 2'd1, 1'b0, 32'h0000_0303, 32'h1111_2222, 0, 32'd0,        1'b1, 4'b0000, 32'd0);
    do_req("stall4",   1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0,        4, 32'h8081_F27F, 1'b0, 4'b1111, 32'd0);

    // Timeout on the short-timeout instance: 1 REQ + 3 WAIT strobe cycles, resp in cycle 5.
    @(negedge clk);
    t_req_valid = 1'b1;
    t_req_addr  = 32'h0000_0040;
    t_sb_q.push_back('{32'd0, 1'b1});
    @(posedge clk);
    #1;
    t_req_valid = 1'b0;
    lat         = 0;
    strobe_cyc  = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (t_read) strobe_cyc++;
      if (t_resp_valid) begin
        lat = k;
        break;
      end
    end
    check("timeout_strobe_cycles", 64'(strobe_cyc), 64'd4);
    check("timeout_latency", 64'(lat), 64'd5);
    @(negedge clk);
    check("timeout_after", {t_read, t_resp_valid, t_req_ready}, 64'b001);

    // Reset during WAIT: strobes drop asynchronously, no response.
    @(negedge clk);
    req_valid   = 1'b1;
    req_write   = 1'b0;
    req_size    = 2'd2;
    req_addr    = 32'h0000_0100;
    waitrequest = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pre_read", 64'(read), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_strobes", {read, write, resp_valid}, 64'd0);
    @(negedge clk);
    reset_n     = 1'b1;
    waitrequest = 1'b0;
    check("rst_ready", 64'(req_ready), 64'd1);
    repeat (4) @(negedge clk);
    readdata = 32'hDEAD_BEEF;
    do_req("post_rst", 1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'd0, 0, 32'hDEAD_BEEF, 1'b0,
           4'b1111, 32'd0);

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(sb_q.size() + t_sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
